// File: rtl/axis_frame_delimiter_if.sv
// AXI-Stream byte channel used on both sides of the frame delimiter.
// The master drives data/valid/last and the slave drives ready.
interface axis_frame_delimiter_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_frame_delimiter.sv
// Inserts tlast into an unterminated AXI-Stream byte stream by frame length, input tlast or idle timeout.
// One beat is held back in H so a timeout can still mark an already-accepted beat as last.
module axis_frame_delimiter #(
  parameter int DATA_WIDTH    = 8,
  parameter int LEN_WIDTH     = 8,
  parameter int TIMEOUT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [LEN_WIDTH-1:0]     cfg_len,
  input  logic [TIMEOUT_WIDTH-1:0] cfg_timeout,
  axis_frame_delimiter_if.slave    s_axis,
  axis_frame_delimiter_if.master   m_axis,
  output logic [15:0]              stat_timeout_flushes
);

  function automatic logic [TIMEOUT_WIDTH-1:0] idle_sat_inc(input logic [TIMEOUT_WIDTH-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  function automatic logic [15:0] stat_sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [DATA_WIDTH-1:0]    r_hold_data;
  logic                     r_hold_valid;
  logic                     r_hold_last;
  logic [DATA_WIDTH-1:0]    r_out_data;
  logic                     r_out_valid;
  logic                     r_out_last;
  logic [LEN_WIDTH-1:0]     r_beat_cnt;
  logic [TIMEOUT_WIDTH-1:0] r_idle_cnt;
  logic [15:0]              r_stat;

  logic                     w_out_free;
  logic                     w_timeout_hit;
  logic                     w_release;
  logic                     w_flush;
  logic                     w_accept;
  logic                     w_eof;
  logic [LEN_WIDTH:0]       w_beat_next;

  assign w_out_free    = !r_out_valid || m_axis.tready;
  assign w_timeout_hit = (cfg_timeout != '0) && (r_idle_cnt >= cfg_timeout);
  assign w_release     = r_hold_valid && (r_hold_last || w_timeout_hit);
  // Ready is withheld during a release so accept and release never coincide.
  assign s_axis.tready = w_out_free && !w_release && !rst;
  assign w_accept      = s_axis.tvalid && s_axis.tready;
  assign w_flush       = w_release && w_out_free;

  // One extra bit keeps beat_cnt+1 from wrapping when beat_cnt is all-ones.
  assign w_beat_next   = {1'b0, r_beat_cnt} + 1'b1;
  assign w_eof         = s_axis.tlast ||
                         ((cfg_len != '0) && (w_beat_next >= {1'b0, cfg_len}));

  assign m_axis.tdata         = r_out_data;
  assign m_axis.tvalid        = r_out_valid;
  assign m_axis.tlast         = r_out_last;
  assign stat_timeout_flushes = r_stat;

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_hold_data <= s_axis.tdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold_valid <= 1'b0;
      r_hold_last  <= 1'b0;
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
      r_out_last   <= 1'b0;
      r_beat_cnt   <= '0;
      r_idle_cnt   <= '0;
      r_stat       <= '0;
    end else if (w_accept) begin
      r_hold_valid <= 1'b1;
      r_hold_last  <= w_eof;
      r_beat_cnt   <= w_eof ? '0 : w_beat_next[LEN_WIDTH-1:0];
      r_idle_cnt   <= '0;
      if (r_hold_valid) begin
        r_out_data  <= r_hold_data;
        r_out_last  <= 1'b0;
        r_out_valid <= 1'b1;
      end else if (m_axis.tready) begin
        r_out_valid <= 1'b0;
      end
    end else if (w_flush) begin
      r_out_data   <= r_hold_data;
      r_out_last   <= 1'b1;
      r_out_valid  <= 1'b1;
      r_hold_valid <= 1'b0;
      r_hold_last  <= 1'b0;
      r_beat_cnt   <= '0;
      r_idle_cnt   <= '0;
      if (!r_hold_last) begin
        r_stat <= stat_sat_inc(r_stat);
      end
    end else begin
      // Idle counting continues under backpressure so a pending flush fires on the first free cycle.
      if (m_axis.tready) begin
        r_out_valid <= 1'b0;
      end
      if (r_hold_valid && !r_hold_last) begin
        r_idle_cnt <= idle_sat_inc(r_idle_cnt);
      end
    end
  end

endmodule

// File: tb/tb_axis_frame_delimiter.sv
// Randomized and directed bench for axis_frame_delimiter against a stream-level frame model.
// Expected beats are queued at input acceptance and popped on each output handshake.
module tb_axis_frame_delimiter;
  localparam int DW = 8;
  localparam int LW = 8;
  localparam int TW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [LW-1:0] cfg_len;
  logic [TW-1:0] cfg_timeout;
  logic [15:0]   stat;

  axis_frame_delimiter_if #(.DATA_WIDTH(DW)) s_if ();
  axis_frame_delimiter_if #(.DATA_WIDTH(DW)) m_if ();

  axis_frame_delimiter #(
    .DATA_WIDTH(DW), .LEN_WIDTH(LW), .TIMEOUT_WIDTH(TW)
  ) dut (
    .clk(clk), .rst(rst), .cfg_len(cfg_len), .cfg_timeout(cfg_timeout),
    .s_axis(s_if.slave), .m_axis(m_if.master), .stat_timeout_flushes(stat)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    frame_beats = 0;
  int    stat_exp = 0;
  int    out_cnt = 0;
  int    bubbles = 0;
  int    acc_cyc = 0;
  int    out_cyc_of[256];
  bit    rnd_bp = 1'b0;
  bit    acc;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // A beat ends its frame on input tlast or when it is the cfg_len-th beat of the frame.
  task automatic model_accept(input logic [7:0] d, input logic t);
    beat_t e;
    e.d = d;
    e.l = t || ((cfg_len != 0) && (frame_beats + 1 >= int'(cfg_len)));
    exp_q.push_back(e);
    frame_beats = e.l ? 0 : frame_beats + 1;
  endtask

  // An idle timeout closes the frame at the most recently accepted beat.
  task automatic model_timeout_close();
    beat_t e;
    e = exp_q.pop_back();
    e.l = 1'b1;
    exp_q.push_back(e);
    frame_beats = 0;
    stat_exp++;
  endtask

  task automatic observe();
    beat_t e;
    cyc++;
    acc = 1'b0;
    if (m_if.tvalid && m_if.tready) begin
      out_cnt++;
      out_cyc_of[m_if.tdata] = cyc;
      check_eq("exp_q_nonempty", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_eq("out_data", 32'(m_if.tdata), 32'(e.d));
        check_eq("out_last", 32'(m_if.tlast), 32'(e.l));
      end
    end
    if (s_if.tvalid && !s_if.tready) bubbles++;
    if (s_if.tvalid && s_if.tready) begin
      acc = 1'b1;
      acc_cyc = cyc;
      model_accept(s_if.tdata, s_if.tlast);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
    if (rnd_bp) m_if.tready = ($urandom_range(0, 99) >= 30);
  endtask

  task automatic send_beat(input logic [7:0] d, input logic t);
    bit done;
    done = 1'b0;
    s_if.tdata  = d;
    s_if.tlast  = t;
    s_if.tvalid = 1'b1;
    for (int i = 0; i < 500 && !done; i++) begin
      cycle();
      done = acc;
    end
    check_eq("send_accepted", 32'(done), 32'd1);
  endtask

  task automatic idle(input int n);
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    repeat (n) cycle();
  endtask

  task automatic drain();
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    for (int i = 0; i < 3000 && exp_q.size() > 0; i++) cycle();
    check_eq("drain_empty", 32'(exp_q.size()), 32'd0);
    cycle();
  endtask

  task automatic apply_reset(input int n);
    rst = 1'b1;
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    repeat (n) begin
      @(negedge clk);
      check_eq("rdy_low_in_rst", 32'(s_if.tready), 32'd0);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    exp_q.delete();
    frame_beats = 0;
    stat_exp = 0;
    check_eq("rst_tvalid", 32'(m_if.tvalid), 32'd0);
    check_eq("rst_tlast", 32'(m_if.tlast), 32'd0);
    check_eq("rst_tdata", 32'(m_if.tdata), 32'd0);
    check_eq("rst_stat", 32'(stat), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    cfg_len = '0;
    cfg_timeout = '0;
    s_if.tdata = '0;
    s_if.tvalid = 1'b0;
    s_if.tlast = 1'b0;
    m_if.tready = 1'b1;
    foreach (out_cyc_of[i]) out_cyc_of[i] = 0;
    @(posedge clk);
    #1;
    apply_reset(3);

    // Length framing: cfg_len=4, eight back-to-back bytes.
    cfg_len = 8'd4;
    bubbles = 0;
    for (int i = 0; i < 8; i++) send_beat(8'(i), 1'b0);
    s_if.tvalid = 1'b0;
    @(negedge clk);
    check_eq("len_rdy_bubble", 32'(s_if.tready), 32'd0);
    observe();
    @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("len_rdy_back", 32'(s_if.tready), 32'd1);
    observe();
    @(posedge clk);
    #1;
    check_eq("len_bubbles", 32'(bubbles), 32'd1);
    drain();

    // Input tlast ends the frame; the next frame counts from zero.
    cfg_len = 8'd0;
    send_beat(8'hA0, 1'b0);
    send_beat(8'hA1, 1'b0);
    send_beat(8'hA2, 1'b1);
    cfg_len = 8'd2;
    send_beat(8'hB0, 1'b0);
    send_beat(8'hB1, 1'b0);
    drain();

    // Idle timeout on a lone beat: flushed six edges after acceptance.
    cfg_len = 8'd0;
    cfg_timeout = 16'd5;
    out_cyc_of[8'h5A] = 0;
    send_beat(8'h5A, 1'b0);
    model_timeout_close();
    drain();
    check_eq("to_latency", 32'(out_cyc_of[8'h5A] - acc_cyc), 32'd7);
    check_eq("to_stat", 32'(stat), 32'(stat_exp));

    // Timeout pending while the output register is stalled.
    cfg_timeout = 16'd2;
    m_if.tready = 1'b0;
    send_beat(8'h10, 1'b0);
    send_beat(8'h11, 1'b0);
    idle(10);
    check_eq("stall_stat_hold", 32'(stat), 32'(stat_exp));
    check_eq("stall_o_valid", 32'(m_if.tvalid), 32'd1);
    model_timeout_close();
    m_if.tready = 1'b1;
    drain();
    check_eq("stall_flush_gap", 32'(out_cyc_of[8'h11] - out_cyc_of[8'h10]), 32'd1);
    check_eq("stall_stat", 32'(stat), 32'(stat_exp));

    // Random backpressure, cfg_len=3, 300 bytes.
    cfg_timeout = 16'd0;
    cfg_len = 8'd3;
    out_cnt = 0;
    rnd_bp = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) == 0) idle(1);
      send_beat(8'(i), 1'b0);
    end
    drain();
    check_eq("bp_count", 32'(out_cnt), 32'd300);

    // Random data with random input tlast, cfg_len=5.
    cfg_len = 8'd5;
    out_cnt = 0;
    for (int i = 0; i < 200; i++) begin
      send_beat(8'($urandom), (i == 199) || ($urandom_range(0, 9) == 0));
    end
    drain();
    check_eq("rt_count", 32'(out_cnt), 32'd200);
    rnd_bp = 1'b0;
    m_if.tready = 1'b1;

    // Reset with H and O both full, then a clean frame.
    cfg_len = 8'd3;
    m_if.tready = 1'b0;
    send_beat(8'h20, 1'b0);
    send_beat(8'h21, 1'b0);
    s_if.tvalid = 1'b0;
    check_eq("pre_rst_o_valid", 32'(m_if.tvalid), 32'd1);
    apply_reset(1);
    m_if.tready = 1'b1;
    out_cnt = 0;
    for (int i = 0; i < 6; i++) send_beat(8'h30 + 8'(i), 1'b0);
    drain();
    check_eq("post_rst_count", 32'(out_cnt), 32'd6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
